// File: rtl/audio_capture_channel_pkg.sv
// Shared types and constants for the audio capture channel: DMA state
// encoding, sample/word widths and the per-word address step.
package audio_capture_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  localparam logic [31:0] ADDR_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/audio_capture_channel_fifo.sv
// Small synchronous show-ahead FIFO: o_head always presents the oldest
// entry, i_flush empties it in one cycle and pushes while full are ignored.
module audio_capture_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_head  = mem[rd_ptr[AW-1:0]];
  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_capture_channel.sv
// Audio capture channel: samples on each sample-clock toggle, queues words
// in a FIFO and drains them with a DMA write master. AUDIO_CAPTURE_MONO_EN packs two left samples per word.
module audio_capture_channel
  import audio_capture_pkg::*;
#(
  parameter int BUFFER_SIZE = 4
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_dma_setup_request,
  input  logic [31:0]         i_dma_setup_count,
  input  logic [31:0]         i_dma_setup_address,
  output logic                o_dma_request,
  output logic [31:0]         o_dma_address,
  output logic [WORD_W-1:0]   o_dma_wdata,
  input  logic                i_dma_ready,
  input  logic                i_input_sample_clock,
  input  logic [SAMPLE_W-1:0] i_input_sample_left,
  input  logic [SAMPLE_W-1:0] i_input_sample_right,
  output logic                o_busy,
  output logic                o_overrun
);

  dma_state_e state, state_next;

  logic [31:0]       count;
  logic [31:0]       address;
  logic [31:0]       pend_count;
  logic [31:0]       pend_address;
  logic              pend_valid;
  logic              last_sample_clock;
  logic              toggle;
  logic              armed;
  logic [WORD_W-1:0] sample_word;
  logic              sample_valid;
  logic [WORD_W-1:0] load_word;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic              setup_now;
  logic              write_done;
  logic [31:0]       setup_address_aligned;
`ifdef AUDIO_CAPTURE_MONO_EN
  logic [SAMPLE_W-1:0] half_word;
  logic                half_valid;
`endif

  assign toggle                = (i_input_sample_clock != last_sample_clock);
  assign armed                 = (count != 32'd0);
  assign setup_now             = i_dma_setup_request && (state != WRITE);
  assign write_done            = (state == WRITE) && i_dma_ready;
  assign setup_address_aligned = {i_dma_setup_address[31:2], 2'b00};
  // A setup outside WRITE flushes at once; one during WRITE flushes when the write completes.
  assign fifo_flush            = setup_now || (write_done && (pend_valid || i_dma_setup_request));
  assign fifo_push             = sample_valid && !fifo_full && !fifo_flush;
  assign fifo_pop              = (state == IDLE) && armed && !fifo_empty && !i_dma_setup_request;
  assign o_busy                = armed || (state != IDLE);

  audio_capture_channel_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_flush   (fifo_flush),
    .i_push    (fifo_push),
    .i_wdata   (sample_word),
    .i_pop     (fifo_pop),
    .o_head    (fifo_head),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full)
  );

  // Sample capture: the word is registered on the toggle and pushed a cycle later.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_sample_clock <= 1'b0;
      sample_valid      <= 1'b0;
      sample_word       <= '0;
`ifdef AUDIO_CAPTURE_MONO_EN
      half_word         <= '0;
      half_valid        <= 1'b0;
`endif
    end else begin
      last_sample_clock <= i_input_sample_clock;
      sample_valid      <= 1'b0;
`ifdef AUDIO_CAPTURE_MONO_EN
      if (fifo_flush || !armed) begin
        half_valid <= 1'b0;
      end else if (toggle) begin
        if (half_valid) begin
          sample_word  <= {half_word, i_input_sample_left};
          sample_valid <= 1'b1;
          half_valid   <= 1'b0;
        end else begin
          half_word  <= i_input_sample_left;
          half_valid <= 1'b1;
        end
      end
`else
      if (toggle && armed && !fifo_flush) begin
        sample_word  <= {i_input_sample_left, i_input_sample_right};
        sample_valid <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_pop) state_next = LOAD;
      LOAD:    state_next = i_dma_setup_request ? IDLE : WRITE;
      WRITE:   if (i_dma_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus outputs, transfer bookkeeping, deferred setup and the sticky overrun flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dma_request <= 1'b0;
      o_dma_address <= '0;
      o_dma_wdata   <= '0;
      o_overrun     <= 1'b0;
      load_word     <= '0;
      count         <= '0;
      address       <= '0;
      pend_count    <= '0;
      pend_address  <= '0;
      pend_valid    <= 1'b0;
    end else begin
      if (fifo_pop) load_word <= fifo_head;

      case (state)
        LOAD: begin
          if (!i_dma_setup_request) begin
            o_dma_wdata   <= load_word;
            o_dma_address <= address;
            o_dma_request <= 1'b1;
          end
        end
        WRITE: begin
          if (i_dma_ready) o_dma_request <= 1'b0;
        end
        default: ;
      endcase

      if (i_dma_setup_request) begin
        o_overrun <= 1'b0;
      end else if (sample_valid && fifo_full && !fifo_flush) begin
        o_overrun <= 1'b1;
      end

      if (setup_now) begin
        count      <= i_dma_setup_count;
        address    <= setup_address_aligned;
        pend_valid <= 1'b0;
      end else if (write_done) begin
        pend_valid <= 1'b0;
        if (i_dma_setup_request) begin
          count   <= i_dma_setup_count;
          address <= setup_address_aligned;
        end else if (pend_valid) begin
          count   <= pend_count;
          address <= pend_address;
        end else begin
          if (count != 32'd0) count <= count - 32'd1;
          address <= address + ADDR_STEP;
        end
      end else if (i_dma_setup_request) begin
        pend_valid   <= 1'b1;
        pend_count   <= i_dma_setup_count;
        pend_address <= setup_address_aligned;
      end
    end
  end

endmodule

// File: tb/tb_audio_capture_channel.sv
// Scoreboard bench for audio_capture_channel: directed toggles push expected
// bus writes into a queue that a separate monitor checks as requests appear.
module tb_audio_capture_channel;

  logic        i_clock;
  logic        i_reset_n;
  logic        i_dma_setup_request;
  logic [31:0] i_dma_setup_count;
  logic [31:0] i_dma_setup_address;
  logic        o_dma_request;
  logic [31:0] o_dma_address;
  logic [31:0] o_dma_wdata;
  logic        i_dma_ready;
  logic        i_input_sample_clock;
  logic [15:0] i_input_sample_left;
  logic [15:0] i_input_sample_right;
  logic        o_busy;
  logic        o_overrun;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic        ready_enable = 1'b0;
  int          ready_delay  = 2;

  audio_capture_channel #(.BUFFER_SIZE(4)) dut (
    .i_clock              (i_clock),
    .i_reset_n            (i_reset_n),
    .i_dma_setup_request  (i_dma_setup_request),
    .i_dma_setup_count    (i_dma_setup_count),
    .i_dma_setup_address  (i_dma_setup_address),
    .o_dma_request        (o_dma_request),
    .o_dma_address        (o_dma_address),
    .o_dma_wdata          (o_dma_wdata),
    .i_dma_ready          (i_dma_ready),
    .i_input_sample_clock (i_input_sample_clock),
    .i_input_sample_left  (i_input_sample_left),
    .i_input_sample_right (i_input_sample_right),
    .o_busy               (o_busy),
    .o_overrun            (o_overrun)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] left, input logic [15:0] right);
    i_input_sample_left  = left;
    i_input_sample_right = right;
    i_input_sample_clock = ~i_input_sample_clock;
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    sb_q.push_back({addr, data});
  endtask

  task automatic armChannel(input logic [31:0] cnt, input logic [31:0] addr);
    i_dma_setup_count   = cnt;
    i_dma_setup_address = addr;
    i_dma_setup_request = 1'b1;
    @(negedge i_clock);
    i_dma_setup_request = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic waitForRequest(input int budget);
    int n = 0;
    while (!o_dma_request && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    checkOutput("request_seen", {31'd0, o_dma_request}, 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || o_busy || o_dma_request) && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    checkOutput("drain_queue", 32'(sb_q.size()), 32'd0);
    checkOutput("drain_busy", {31'd0, o_busy}, 32'd0);
  endtask

  // Bus slave: pulses ready for one cycle ready_delay cycles after a request appears.
  initial begin
    int waited = 0;
    i_dma_ready = 1'b0;
    forever begin
      @(negedge i_clock);
      if (o_dma_request && ready_enable) begin
        if (waited == ready_delay) begin
          i_dma_ready = 1'b1;
          @(negedge i_clock);
          i_dma_ready = 1'b0;
          waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // Monitor: each new request must match the next queued write and stay stable while held.
  initial begin
    logic        prev_req = 1'b0;
    logic        hold_known = 1'b0;
    logic [63:0] exp_item = '0;
    forever begin
      @(negedge i_clock);
      if (o_dma_request && !prev_req) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          hold_known = 1'b0;
          $display("[TB] FAIL unexpected_write actual=0x%08h@0x%08h expected=none", o_dma_wdata, o_dma_address);
        end else begin
          exp_item   = sb_q.pop_front();
          hold_known = 1'b1;
          checkOutput("write_addr", o_dma_address, exp_item[63:32]);
          checkOutput("write_data", o_dma_wdata, exp_item[31:0]);
        end
      end else if (o_dma_request && hold_known) begin
        checkOutput("hold_addr", o_dma_address, exp_item[63:32]);
        checkOutput("hold_data", o_dma_wdata, exp_item[31:0]);
      end
      prev_req = o_dma_request;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset_n            = 1'b0;
    i_dma_setup_request  = 1'b0;
    i_dma_setup_count    = '0;
    i_dma_setup_address  = '0;
    i_input_sample_clock = 1'b0;
    i_input_sample_left  = '0;
    i_input_sample_right = '0;

    waitCycles(3);
    checkOutput("reset_request", {31'd0, o_dma_request}, 32'd0);
    checkOutput("reset_address", o_dma_address, 32'd0);
    checkOutput("reset_wdata", o_dma_wdata, 32'd0);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset_overrun", {31'd0, o_overrun}, 32'd0);
    i_reset_n = 1'b1;
    waitCycles(2);

`ifdef AUDIO_CAPTURE_MONO_EN
    $display("[TB] mono packing");
    ready_enable = 1'b1;
    armChannel(32'd1, 32'h0000_8000);
    expectWrite(32'h0000_8000, 32'hAAAA_BBBB);
    applyStimulus(16'hAAAA, 16'h1234);
    waitCycles(3);
    applyStimulus(16'hBBBB, 16'h5678);
    waitDrain(100);

    armChannel(32'd1, 32'h0000_9000);
    applyStimulus(16'hCCCC, 16'h0000);
    waitCycles(3);
    armChannel(32'd1, 32'h0000_9000);
    applyStimulus(16'hDDDD, 16'h0000);
    waitCycles(10);
    checkOutput("mono_half_discarded", {31'd0, o_dma_request}, 32'd0);
    checkOutput("mono_still_armed", {31'd0, o_busy}, 32'd1);
    checkOutput("mono_overrun", {31'd0, o_overrun}, 32'd0);
`else
    $display("[TB] three stereo writes");
    ready_enable = 1'b1;
    ready_delay  = 2;
    armChannel(32'd3, 32'h0000_1000);
    checkOutput("armed_busy", {31'd0, o_busy}, 32'd1);
    expectWrite(32'h0000_1000, 32'h1111_2222);
    expectWrite(32'h0000_1004, 32'h3333_4444);
    expectWrite(32'h0000_1008, 32'h5555_6666);
    applyStimulus(16'h1111, 16'h2222);
    waitCycles(3);
    checkOutput("latency_early", {31'd0, o_dma_request}, 32'd0);
    waitCycles(1);
    checkOutput("latency_4", {31'd0, o_dma_request}, 32'd1);
    waitCycles(4);
    applyStimulus(16'h3333, 16'h4444);
    waitCycles(6);
    applyStimulus(16'h5555, 16'h6666);
    waitDrain(200);
    applyStimulus(16'h7777, 16'h8888);
    waitCycles(10);
    checkOutput("disarmed_toggle_request", {31'd0, o_dma_request}, 32'd0);
    checkOutput("disarmed_toggle_overrun", {31'd0, o_overrun}, 32'd0);

    $display("[TB] stalled write, overrun, setup during write");
    ready_enable = 1'b0;
    armChannel(32'd16, 32'h0000_3000);
    expectWrite(32'h0000_3000, 32'hA001_B001);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(16'hA000 + 16'(i), 16'hB000 + 16'(i));
      waitCycles(4);
      if (i == 5) checkOutput("overrun_before_full", {31'd0, o_overrun}, 32'd0);
    end
    checkOutput("overrun_set", {31'd0, o_overrun}, 32'd1);
    checkOutput("stuck_request", {31'd0, o_dma_request}, 32'd1);
    checkOutput("stuck_address", o_dma_address, 32'h0000_3000);
    armChannel(32'd2, 32'h0000_2000);
    checkOutput("overrun_cleared", {31'd0, o_overrun}, 32'd0);
    checkOutput("pending_old_address", o_dma_address, 32'h0000_3000);
    ready_enable = 1'b1;
    waitCycles(10);
    checkOutput("flushed_no_request", {31'd0, o_dma_request}, 32'd0);
    checkOutput("pending_busy", {31'd0, o_busy}, 32'd1);
    expectWrite(32'h0000_2000, 32'hC001_0002);
    expectWrite(32'h0000_2004, 32'hC003_0004);
    applyStimulus(16'hC001, 16'h0002);
    waitCycles(6);
    applyStimulus(16'hC003, 16'h0004);
    waitDrain(200);
    applyStimulus(16'hC005, 16'h0006);
    waitCycles(10);
    checkOutput("after_two_no_request", {31'd0, o_dma_request}, 32'd0);

    $display("[TB] count zero");
    armChannel(32'd0, 32'h0000_4000);
    checkOutput("count0_busy", {31'd0, o_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'hD000 + 16'(i), 16'hE000 + 16'(i));
      waitCycles(3);
    end
    waitCycles(5);
    checkOutput("count0_request", {31'd0, o_dma_request}, 32'd0);
    checkOutput("count0_overrun", {31'd0, o_overrun}, 32'd0);

    $display("[TB] reset during write");
    ready_enable = 1'b0;
    armChannel(32'd1, 32'h0000_6000);
    expectWrite(32'h0000_6000, 32'hCAFE_F00D);
    applyStimulus(16'hCAFE, 16'hF00D);
    waitForRequest(20);
    waitCycles(2);
    i_reset_n = 1'b0;
    #1;
    checkOutput("abort_request", {31'd0, o_dma_request}, 32'd0);
    checkOutput("abort_address", o_dma_address, 32'd0);
    checkOutput("abort_wdata", o_dma_wdata, 32'd0);
    checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("abort_overrun", {31'd0, o_overrun}, 32'd0);
    @(negedge i_clock);
    i_reset_n    = 1'b1;
    ready_enable = 1'b1;
    waitCycles(2);
    armChannel(32'd1, 32'h0000_7000);
    expectWrite(32'h0000_7000, 32'h1234_5678);
    applyStimulus(16'h1234, 16'h5678);
    waitDrain(100);
`endif

    checkOutput("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
